mhp_responder: RTL and testbench



---
 rtl/mhp_pkg.sv | 40 ++++
 rtl/mhp_responder_if.sv | 20 ++
 rtl/mhp_tx_serializer.sv | 88 ++++++++
 rtl/mhp_responder.sv | 184 ++++++++++++++++++
 tb/tb_mhp_responder.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/mhp_pkg.sv
// Shared MHP link definitions: frame type codes, header constants and FSM state encoding.
// Imported by the responder top and its transmit serializer.
package mhp_pkg;

   localparam int          HDR_BYTES = 9;
   localparam int          RX_KEEP   = 14;
   localparam logic [15:0] BROADCAST = 16'hFFFF;

   typedef enum logic [6:0] {
      PING        = 7'h01,
      PONG        = 7'h02,
      ADDR_REQ    = 7'h03,
      ADDR_ASSIGN = 7'h04,
      TASK        = 7'h0D,
      ADD_RESULT  = 7'h0E,
      READY       = 7'h12,
      READY_ACK   = 7'h13
   } mhp_type_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RX,
      ST_DECODE,
      ST_TX_A,
      ST_TX_B
   } state_e;

   // Everything the serializer needs to build one reply; payload[7:0] is payload byte 0.
   typedef struct packed {
      logic [6:0]  kind;
      logic [15:0] dst;
      logic [15:0] src;
      logic [39:0] payload;
   } reply_hdr_t;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/mhp_responder_if.sv
// Byte-wide eth read/write link: receive-FIFO pop port plus transmit wvalid/wready port.
// master is the responder side, slave is the FIFO/transmitter side.
interface mhp_responder_if;
   logic [7:0] i_rdata;
   logic       i_rready;
   logic       o_rreq;
   logic [7:0] o_wdata;
   logic       i_wready;
   logic       o_wvalid;

   modport master (
      input  i_rdata, i_rready, i_wready,
      output o_rreq, o_wdata, o_wvalid
   );

   modport slave (
      output i_rdata, i_rready, i_wready,
      input  o_rreq, o_wdata, o_wvalid
   );
endinterface

// File: rtl/mhp_tx_serializer.sv
// Emits one zero-padded MHP reply frame (9 header bytes + PAYLOAD_BYTES) under wvalid/wready.
// Header fields are captured on i_start; o_done pulses in the cycle the last byte transfers.
module mhp_tx_serializer
   import mhp_pkg::*;
#(
   parameter int PAYLOAD_BYTES = 37
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  reply_hdr_t i_hdr,
   input  logic       i_wready,
   output logic       o_wvalid,
   output logic [7:0] o_wdata,
   output logic       o_done
);

   localparam int              FRAME_BYTES = HDR_BYTES + PAYLOAD_BYTES;
   localparam int              IW          = $clog2(FRAME_BYTES);
   localparam logic [IW-1:0]   LAST        = IW'(FRAME_BYTES - 1);
   localparam logic [15:0]     SIZE_FIELD  = 16'(PAYLOAD_BYTES);

   reply_hdr_t    hdr_q, hdr_d;
   logic [IW-1:0] idx_q, idx_d, idx_nxt;
   logic          wvalid_q, wvalid_d;
   logic [7:0]    wdata_q, wdata_d;
   logic          xfer;

   function automatic logic [7:0] frame_byte(input logic [IW-1:0] idx, input reply_hdr_t h);
      int i;
      i = int'(idx);
      frame_byte = 8'h00;
      unique case (i)
         2:       frame_byte = h.dst[15:8];
         3:       frame_byte = h.dst[7:0];
         4:       frame_byte = h.src[15:8];
         5:       frame_byte = h.src[7:0];
         6:       frame_byte = SIZE_FIELD[15:8];
         7:       frame_byte = SIZE_FIELD[7:0];
         8:       frame_byte = {1'b0, h.kind};
         default: if (i >= HDR_BYTES && i < HDR_BYTES + 5) frame_byte = h.payload[8*(i-HDR_BYTES) +: 8];
      endcase
   endfunction

   assign xfer    = wvalid_q && i_wready;
   assign idx_nxt = idx_q + IW'(1);

   always_comb begin
      hdr_d    = hdr_q;
      idx_d    = idx_q;
      wvalid_d = wvalid_q;
      wdata_d  = wdata_q;
      if (i_start) begin
         hdr_d    = i_hdr;
         idx_d    = '0;
         wvalid_d = 1'b1;
         wdata_d  = frame_byte('0, i_hdr);
      end else if (xfer) begin
         if (idx_q == LAST) begin
            wvalid_d = 1'b0;
            wdata_d  = 8'h00;
         end else begin
            idx_d   = idx_nxt;
            wdata_d = frame_byte(idx_nxt, hdr_q);
         end
      end
   end

   // NOTE: sequential state is only ever updated with non-blocking assignments.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         hdr_q    <= '0;
         idx_q    <= '0;
         wvalid_q <= 1'b0;
         wdata_q  <= 8'h00;
      end else begin
         hdr_q    <= hdr_d;
         idx_q    <= idx_d;
         wvalid_q <= wvalid_d;
         wdata_q  <= wdata_d;
      end
   end

   assign o_wvalid = wvalid_q;
   assign o_wdata  = wdata_q;
   assign o_done   = xfer && (idx_q == LAST);

endmodule

// File: rtl/mhp_responder.sv
// MHP host responder: drains one frame, decodes it, answers address/ready/ping requests,
// checks returned add results and keeps saturating pass/fail/drop statistics.
module mhp_responder
   import mhp_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR     = 16'h0010,
   parameter int          PAYLOAD_BYTES = 37
) (
   input  logic            i_clk,
   input  logic            i_rst,
   mhp_responder_if.master eth,
   input  logic [15:0]     i_node_addr,
   input  logic [15:0]     i_op_a,
   input  logic [15:0]     i_op_b,
   output logic            o_busy,
   output logic [7:0]      o_pass_cnt,
   output logic [7:0]      o_fail_cnt,
   output logic [7:0]      o_drop_cnt
);

   state_e      state_q, state_d;
   logic [3:0]  rx_cnt_q, rx_cnt_d;
   logic        pend_q, pend_d;
   logic [7:0]  rx_buf_q [RX_KEEP];
   logic [7:0]  rx_buf_d [RX_KEEP];
   logic [15:0] next_addr_q, next_addr_d;
   logic        exp_valid_q, exp_valid_d;
   logic [15:0] op_a_q, op_a_d, op_b_q, op_b_d;
   logic [7:0]  pass_q, pass_d, fail_q, fail_d, drop_q, drop_d;

   logic        rreq, tx_start, tx_done, accept;
   reply_hdr_t  tx_hdr;
   logic [15:0] rx_dst, rx_src, rx_word, expected;
   logic [6:0]  rx_type;
   logic        rx_dir;

   assign rx_dst   = {rx_buf_q[2], rx_buf_q[3]};
   assign rx_src   = {rx_buf_q[4], rx_buf_q[5]};
   assign rx_dir   = rx_buf_q[8][7];
   assign rx_type  = rx_buf_q[8][6:0];
   assign rx_word  = {rx_buf_q[10], rx_buf_q[9]};
   assign expected = op_a_q + op_b_q;
   assign accept   = (rx_cnt_q >= 4'(HDR_BYTES)) && rx_dir &&
                     (rx_dst == BROADCAST || rx_dst == i_node_addr) &&
                     (rx_type inside {ADDR_REQ, READY, PING, ADD_RESULT});

   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (eth.i_rready) state_d = ST_RX;
         ST_RX:     if (!eth.i_rready) state_d = ST_DECODE;
         ST_DECODE: state_d = (accept && rx_type != ADD_RESULT) ? ST_TX_A : ST_IDLE;
         ST_TX_A:   if (tx_done) state_d = (rx_type == READY) ? ST_TX_B : ST_IDLE;
         ST_TX_B:   if (tx_done) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      rreq       = 1'b0;
      tx_start   = 1'b0;
      tx_hdr     = '0;
      tx_hdr.src = i_node_addr;
      tx_hdr.dst = rx_src;
      unique case (state_q)
         ST_IDLE, ST_RX: rreq = eth.i_rready && !i_rst;
         ST_DECODE: begin
            tx_start = accept && (rx_type != ADD_RESULT);
            case (rx_type)
               ADDR_REQ: begin
                  tx_hdr.kind    = ADDR_ASSIGN;
                  tx_hdr.dst     = BROADCAST;
                  tx_hdr.payload = {24'h0, next_addr_q};
               end
               READY:    tx_hdr.kind = READY_ACK;
               PING: begin
                  tx_hdr.kind    = PONG;
                  tx_hdr.payload = {16'h0, rx_buf_q[11], rx_buf_q[10], rx_buf_q[9]};
               end
               default: ;
            endcase
         end
         ST_TX_A: begin
            // The task follows the ack back to back, so it is launched on the ack's done.
            tx_start       = tx_done && (rx_type == READY);
            tx_hdr.kind    = TASK;
            tx_hdr.payload = {op_b_q, op_a_q, 8'h01};
         end
         default: ;
      endcase
   end

   always_comb begin
      rx_cnt_d    = rx_cnt_q;
      pend_d      = rreq;
      rx_buf_d    = rx_buf_q;
      next_addr_d = next_addr_q;
      exp_valid_d = exp_valid_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      pass_d      = pass_q;
      fail_d      = fail_q;
      drop_d      = drop_q;
      if (state_q == ST_IDLE) rx_cnt_d = '0;
      if (pend_q) begin
         if (rx_cnt_q < 4'(RX_KEEP)) rx_buf_d[rx_cnt_q] = eth.i_rdata;
         if (rx_cnt_q != 4'hF)       rx_cnt_d = rx_cnt_q + 4'd1;
      end
      if (state_q == ST_DECODE) begin
         if (!accept) begin
            drop_d = sat_inc(drop_q);
         end else begin
            case (rx_type)
               ADDR_REQ: next_addr_d = next_addr_q + 16'd1;
               READY: begin
                  op_a_d      = i_op_a;
                  op_b_d      = i_op_b;
                  exp_valid_d = 1'b1;
               end
               ADD_RESULT: begin
                  if (!exp_valid_q)           drop_d = sat_inc(drop_q);
                  else if (rx_word == expected) pass_d = sat_inc(pass_q);
                  else                        fail_d = sat_inc(fail_q);
                  exp_valid_d = 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rx_cnt_q    <= '0;
         pend_q      <= 1'b0;
         next_addr_q <= BASE_ADDR;
         exp_valid_q <= 1'b0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         pass_q      <= '0;
         fail_q      <= '0;
         drop_q      <= '0;
      end else begin
         rx_cnt_q    <= rx_cnt_d;
         pend_q      <= pend_d;
         next_addr_q <= next_addr_d;
         exp_valid_q <= exp_valid_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
         drop_q      <= drop_d;
      end
   end

   // NOTE: the frame buffer has no reset; rx_cnt_q gates every use of its contents.
   always_ff @(posedge i_clk) begin
      rx_buf_q <= rx_buf_d;
   end

   mhp_tx_serializer #(.PAYLOAD_BYTES(PAYLOAD_BYTES)) u_tx (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_start  (tx_start),
      .i_hdr    (tx_hdr),
      .i_wready (eth.i_wready),
      .o_wvalid (eth.o_wvalid),
      .o_wdata  (eth.o_wdata),
      .o_done   (tx_done)
   );

   assign eth.o_rreq = rreq;
   assign o_busy     = (state_q != ST_IDLE);
   assign o_pass_cnt = pass_q;
   assign o_fail_cnt = fail_q;
   assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_mhp_responder.sv
// Directed bench for mhp_responder: a vector table of request frames with hand-computed replies
// and statistics, plus hand-written sequences for stalled transmit and mid-reply reset.
module tb_mhp_responder;

   localparam int FRAME = 46;

   typedef struct {
      string       name;
      logic [15:0] dst;
      logic [15:0] src;
      logic        dir;
      logic [6:0]  kind;
      logic [39:0] pay;
      int          len;
      logic [15:0] op_a;
      logic [15:0] op_b;
      bit          rand_wr;
      int          n_reply;
      logic [6:0]  a_kind;
      logic [15:0] a_dst;
      logic [39:0] a_pay;
      logic [39:0] b_pay;
      logic [7:0]  pass;
      logic [7:0]  fail;
      logic [7:0]  drop;
   } vec_t;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [15:0] node_addr = 16'h0010;
   logic [15:0] op_a = 16'h0, op_b = 16'h0;
   logic        o_busy;
   logic [7:0]  o_pass_cnt, o_fail_cnt, o_drop_cnt;

   mhp_responder_if eth();

   mhp_responder #(.BASE_ADDR(16'h0010), .PAYLOAD_BYTES(37)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .eth         (eth),
      .i_node_addr (node_addr),
      .i_op_a      (op_a),
      .i_op_b      (op_b),
      .o_busy      (o_busy),
      .o_pass_cnt  (o_pass_cnt),
      .o_fail_cnt  (o_fail_cnt),
      .o_drop_cnt  (o_drop_cnt)
   );

   always #5 i_clk = ~i_clk;

   int         n_total = 0;
   int         n_bad = 0;
   logic [7:0] rxq [$];
   logic [7:0] txq [$];
   bit         rand_wr = 1'b0;
   bit         stall_prev = 1'b0;
   logic [7:0] wdata_prev = 8'h00;
   int         stall_seen = 0;
   int         stall_bad = 0;
   vec_t       vecs [14];

   // Receive FIFO model: one-cycle pop latency, rready means bytes are still queued.
   always @(posedge i_clk) begin
      if (eth.o_rreq && rxq.size() > 0) eth.i_rdata <= rxq.pop_front();
      eth.i_rready <= (rxq.size() != 0);
   end

   // Transmit sink: picks wready for the coming edge and logs bytes that will transfer on it.
   always @(negedge i_clk) begin
      if (stall_prev) begin
         stall_seen++;
         if (!eth.o_wvalid || eth.o_wdata != wdata_prev) stall_bad++;
      end
      eth.i_wready = rand_wr ? 1'($urandom_range(0, 1)) : 1'b1;
      stall_prev   = eth.o_wvalid && !eth.i_wready;
      wdata_prev   = eth.o_wdata;
      if (eth.o_wvalid && eth.i_wready) txq.push_back(eth.o_wdata);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input logic [15:0] dst, input logic [15:0] src,
                               input logic dir, input logic [6:0] kind, input logic [39:0] pay,
                               input int len, input logic [15:0] oa, input logic [15:0] ob,
                               input bit rw, input int n, input logic [6:0] ak,
                               input logic [15:0] ad, input logic [39:0] ap, input logic [39:0] bp,
                               input logic [7:0] p, input logic [7:0] f, input logic [7:0] d);
      vec_t v;
      v.name = name; v.dst = dst; v.src = src; v.dir = dir; v.kind = kind; v.pay = pay;
      v.len = len; v.op_a = oa; v.op_b = ob; v.rand_wr = rw; v.n_reply = n;
      v.a_kind = ak; v.a_dst = ad; v.a_pay = ap; v.b_pay = bp;
      v.pass = p; v.fail = f; v.drop = d;
      return v;
   endfunction

   task automatic push_frame(input vec_t v);
      logic [7:0] fr [20];
      fr[0] = 8'h5A; fr[1] = 8'hC3;
      fr[2] = v.dst[15:8]; fr[3] = v.dst[7:0];
      fr[4] = v.src[15:8]; fr[5] = v.src[7:0];
      fr[6] = 8'h00;       fr[7] = 8'(v.len - 9);
      fr[8] = {v.dir, v.kind};
      for (int i = 0; i < 5; i++) fr[9+i] = v.pay[8*i +: 8];
      for (int i = 14; i < 20; i++) fr[i] = 8'h70 + 8'(i);
      @(negedge i_clk);
      for (int i = 0; i < v.len; i++) rxq.push_back(fr[i]);
   endtask

   task automatic wait_idle(input string name);
      int cyc = 0;
      repeat (3) @(negedge i_clk);
      while ((o_busy || rxq.size() != 0) && cyc < 3000) begin
         @(negedge i_clk);
         cyc++;
      end
      check({name, " idle"}, 64'(o_busy), 64'(0));
   endtask

   task automatic check_frame(input string name, input int b, input logic [6:0] kind,
                              input logic [15:0] dst, input logic [39:0] pay);
      int nz = 0;
      check({name, " scs"},  64'({txq[b],   txq[b+1]}), 64'(0));
      check({name, " dst"},  64'({txq[b+2], txq[b+3]}), 64'(dst));
      check({name, " src"},  64'({txq[b+4], txq[b+5]}), 64'(16'h0010));
      check({name, " size"}, 64'({txq[b+6], txq[b+7]}), 64'(37));
      check({name, " type"}, 64'(txq[b+8]), 64'({1'b0, kind}));
      check({name, " pay"},  64'({txq[b+13], txq[b+12], txq[b+11], txq[b+10], txq[b+9]}), 64'(pay));
      for (int i = 14; i < FRAME; i++) if (txq[b+i] != 8'h00) nz++;
      check({name, " pad"}, 64'(nz), 64'(0));
   endtask

   task automatic run_vec(input vec_t v);
      txq.delete();
      op_a    = v.op_a;
      op_b    = v.op_b;
      rand_wr = v.rand_wr;
      push_frame(v);
      wait_idle(v.name);
      check({v.name, " nbytes"}, 64'(txq.size()), 64'(v.n_reply * FRAME));
      if (v.n_reply >= 1 && txq.size() >= FRAME)
         check_frame({v.name, " A"}, 0, v.a_kind, v.a_dst, v.a_pay);
      if (v.n_reply == 2 && txq.size() >= 2 * FRAME)
         check_frame({v.name, " B"}, FRAME, 7'h0D, v.src, v.b_pay);
      check({v.name, " pass"}, 64'(o_pass_cnt), 64'(v.pass));
      check({v.name, " fail"}, 64'(o_fail_cnt), 64'(v.fail));
      check({v.name, " drop"}, 64'(o_drop_cnt), 64'(v.drop));
   endtask

   initial begin
      vec_t rv;
      int   cyc;
      //               name          dst       src       dir kind   payload           len op_a      op_b     rw n  akind  adst      apay              bpay              p     f     d
      vecs[0]  = mk("addr1",     16'hFFFF, 16'h0000, 1, 7'h03, 40'h0,          14, 16'h0,    16'h0,    0, 1, 7'h04, 16'hFFFF, 40'h0010,         40'h0,            8'd0, 8'd0, 8'd0);
      vecs[1]  = mk("addr2",     16'hFFFF, 16'h0000, 1, 7'h03, 40'h0,          14, 16'h0,    16'h0,    0, 1, 7'h04, 16'hFFFF, 40'h0011,         40'h0,            8'd0, 8'd0, 8'd0);
      vecs[2]  = mk("ready1",    16'h0010, 16'h0022, 1, 7'h12, 40'h0,          14, 16'h1234, 16'h0F00, 0, 2, 7'h13, 16'h0022, 40'h0,            40'h0F00123401,   8'd0, 8'd0, 8'd0);
      vecs[3]  = mk("res_pass",  16'h0010, 16'h0022, 1, 7'h0E, 40'h2134,       14, 16'h0,    16'h0,    0, 0, 7'h00, 16'h0,    40'h0,            40'h0,            8'd1, 8'd0, 8'd0);
      vecs[4]  = mk("res_noexp", 16'h0010, 16'h0022, 1, 7'h0E, 40'h0,          14, 16'h0,    16'h0,    0, 0, 7'h00, 16'h0,    40'h0,            40'h0,            8'd1, 8'd0, 8'd1);
      vecs[5]  = mk("dst_other", 16'h0099, 16'h0022, 1, 7'h12, 40'h0,          14, 16'h0,    16'h0,    0, 0, 7'h00, 16'h0,    40'h0,            40'h0,            8'd1, 8'd0, 8'd2);
      vecs[6]  = mk("runt",      16'hFFFF, 16'h0000, 1, 7'h03, 40'h0,           5, 16'h0,    16'h0,    0, 0, 7'h00, 16'h0,    40'h0,            40'h0,            8'd1, 8'd0, 8'd3);
      vecs[7]  = mk("dir0",      16'h0010, 16'h0022, 0, 7'h01, 40'hCCBBAA,     14, 16'h0,    16'h0,    0, 0, 7'h00, 16'h0,    40'h0,            40'h0,            8'd1, 8'd0, 8'd4);
      vecs[8]  = mk("unknown",   16'hFFFF, 16'h0022, 1, 7'h55, 40'h0,          14, 16'h0,    16'h0,    0, 0, 7'h00, 16'h0,    40'h0,            40'h0,            8'd1, 8'd0, 8'd5);
      vecs[9]  = mk("ready_wrap",16'h0010, 16'h0044, 1, 7'h12, 40'h0,          14, 16'hFFFF, 16'h0002, 0, 2, 7'h13, 16'h0044, 40'h0,            40'h0002FFFF01,   8'd1, 8'd0, 8'd5);
      vecs[10] = mk("ready_ovr", 16'hFFFF, 16'h0044, 1, 7'h12, 40'h0,          14, 16'h1000, 16'h0001, 0, 2, 7'h13, 16'h0044, 40'h0,            40'h0001100001,   8'd1, 8'd0, 8'd5);
      vecs[11] = mk("res_fail",  16'h0010, 16'h0044, 1, 7'h0E, 40'h0001,       14, 16'h7777, 16'h1111, 0, 0, 7'h00, 16'h0,    40'h0,            40'h0,            8'd1, 8'd1, 8'd5);
      vecs[12] = mk("ping_long", 16'hFFFF, 16'h0033, 1, 7'h01, 40'hEEDDCCBBAA, 20, 16'h0,    16'h0,    0, 1, 7'h02, 16'h0033, 40'h0000CCBBAA,   40'h0,            8'd1, 8'd1, 8'd5);
      vecs[13] = mk("ping_stall",16'h0010, 16'h0055, 1, 7'h01, 40'h0000CCBBAA, 14, 16'h0,    16'h0,    1, 1, 7'h02, 16'h0055, 40'h0000CCBBAA,   40'h0,            8'd1, 8'd1, 8'd5);

      repeat (3) @(negedge i_clk);
      check("reset rreq",   64'(eth.o_rreq),   64'(0));
      check("reset wvalid", 64'(eth.o_wvalid), 64'(0));
      check("reset wdata",  64'(eth.o_wdata),  64'(0));
      check("reset busy",   64'(o_busy),       64'(0));
      check("reset cnts",   64'({o_pass_cnt, o_fail_cnt, o_drop_cnt}), 64'(0));
      i_rst = 1'b0;
      repeat (2) @(negedge i_clk);

      for (int i = 0; i < 14; i++) run_vec(vecs[i]);
      rand_wr = 1'b0;
      check("stalls seen", 64'(stall_seen > 0), 64'(1));
      check("stall hold",  64'(stall_bad),      64'(0));

      // Reset in the middle of a reply: link goes quiet and the address pool restarts.
      txq.delete();
      push_frame(vecs[0]);
      cyc = 0;
      while (txq.size() < 20 && cyc < 500) begin
         @(negedge i_clk);
         cyc++;
      end
      check("rst reached byte 20", 64'(txq.size() >= 20), 64'(1));
      i_rst = 1'b1;
      @(negedge i_clk);
      check("rst wvalid", 64'(eth.o_wvalid), 64'(0));
      check("rst wdata",  64'(eth.o_wdata),  64'(0));
      check("rst busy",   64'(o_busy),       64'(0));
      check("rst cnts",   64'({o_pass_cnt, o_fail_cnt, o_drop_cnt}), 64'(0));
      i_rst = 1'b0;
      repeat (2) @(negedge i_clk);
      rv = vecs[0];
      rv.name = "addr_after_rst";
      run_vec(rv);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
